// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared constants and helpers for the raster timing generator.
// Provides the 640x480@60 default timing, the coordinate width and small helper
// functions used to derive totals and decode sync windows.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;

    // 640x480@60 with a 25 MHz pixel rate derived from a 50 MHz clock
    localparam int unsigned DEF_H_ACTIVE   = 640;
    localparam int unsigned DEF_H_FP       = 16;
    localparam int unsigned DEF_H_SYNC     = 96;
    localparam int unsigned DEF_H_BP       = 48;
    localparam int unsigned DEF_V_ACTIVE   = 480;
    localparam int unsigned DEF_V_FP       = 10;
    localparam int unsigned DEF_V_SYNC     = 2;
    localparam int unsigned DEF_V_BP       = 33;
    localparam int unsigned DEF_CLK_DIV    = 2;
    localparam int unsigned DEF_PIPE_DELAY = 2;

    // Total period of one axis: active + front porch + sync + back porch.
    function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                               input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Sync level for a position: 'active' inside [start_pos, end_pos), inverted elsewhere.
    function automatic logic sync_level(input int unsigned pos, input int unsigned start_pos,
                                        input int unsigned end_pos, input logic active);
        return ((pos >= start_pos) && (pos < end_pos)) ? active : ~active;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line
// Shift register that delays a sync signal by DEPTH clocks; every stage resets
// asynchronously to RESET_VAL so no pending pulse survives a reset.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   i_d   - raw sync in
//   o_q   - sync delayed by DEPTH clocks (i_d itself when DEPTH == 0)
module sync_delay_line #(
    parameter int unsigned DEPTH     = 2,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    if (DEPTH == 0) begin : g_bypass
        assign o_q = i_d;
    end else if (DEPTH == 1) begin : g_single
        logic r_stage;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stage <= RESET_VAL;
            end else begin
                r_stage <= i_d;
            end
        end
        assign o_q = r_stage;
    end else begin : g_shift
        logic [DEPTH-1:0] r_stage;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stage <= {DEPTH{RESET_VAL}};
            end else begin
                r_stage <= {r_stage[DEPTH-2:0], i_d};
            end
        end
        assign o_q = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing stage: pixel-enable divider, horizontal/vertical counters,
// visible window, line/frame markers, frame counter and latency-matched syncs.
// Ports:
//   clk, rst_n         - system clock, asynchronous active-low reset
//   xOrd, yOrd         - current raster position
//   visible            - position lies inside the active window
//   pixEn              - one-clk pulse per pixel advance
//   hsync, vsync       - syncs delayed by PIPE_DELAY clocks
//   lineStart          - one-clk pulse on the first clk of each line
//   frameStart         - one-clk pulse on the first clk of each frame
//   frameCount         - number of frame starts seen, wrapping at 8 bits
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter logic        SYNC_ACTIVE = 1'b0,
    parameter int unsigned CLK_DIV     = DEF_CLK_DIV,
    parameter int unsigned PIPE_DELAY  = DEF_PIPE_DELAY
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [COORD_W-1:0] xOrd,
    output logic [COORD_W-1:0] yOrd,
    output logic               visible,
    output logic               pixEn,
    output logic               hsync,
    output logic               vsync,
    output logic               lineStart,
    output logic               frameStart,
    output logic [7:0]         frameCount
);

    localparam int unsigned H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [3:0]         DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0]         r_div_cnt;
    logic               r_pix_en;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_visible;
    logic               r_line_start;
    logic               r_frame_start;
    logic [7:0]         r_frame_cnt;
    logic               r_hsync_raw;
    logic               r_vsync_raw;

    logic [COORD_W-1:0] w_x_next;
    logic [COORD_W-1:0] w_y_next;
    logic               w_at_origin;

    // Pixel divider; with CLK_DIV == 1 the compare is always true, so pixEn stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_pix_en  <= 1'b0;
        end else begin
            r_pix_en  <= (r_div_cnt == DIV_LAST);
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 4'd1;
        end
    end

    always_comb begin
        w_x_next = r_x + COORD_W'(1);
        w_y_next = r_y;
        if (r_x == X_LAST) begin
            w_x_next = '0;
            w_y_next = (r_y == Y_LAST) ? '0 : r_y + COORD_W'(1);
        end
    end

    assign w_at_origin = (w_x_next == '0) && (w_y_next == '0);

    // Everything derived from position is registered from the next position on the
    // advancing edge, so it always matches xOrd/yOrd. Markers clear on every other edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x           <= X_LAST;
            r_y           <= Y_LAST;
            r_visible     <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
            r_hsync_raw   <= ~SYNC_ACTIVE;
            r_vsync_raw   <= ~SYNC_ACTIVE;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (r_pix_en) begin
                r_x           <= w_x_next;
                r_y           <= w_y_next;
                r_visible     <= (32'(w_x_next) < H_ACTIVE) && (32'(w_y_next) < V_ACTIVE);
                r_line_start  <= (w_x_next == '0);
                r_frame_start <= w_at_origin;
                r_hsync_raw   <= sync_level(32'(w_x_next), HS_START, HS_END, SYNC_ACTIVE);
                r_vsync_raw   <= sync_level(32'(w_y_next), VS_START, VS_END, SYNC_ACTIVE);
                if (w_at_origin) begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

    sync_delay_line #(
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (~SYNC_ACTIVE)
    ) u_hsync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (r_hsync_raw),
        .o_q   (hsync)
    );

    sync_delay_line #(
        .DEPTH     (PIPE_DELAY),
        .RESET_VAL (~SYNC_ACTIVE)
    ) u_vsync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (r_vsync_raw),
        .o_q   (vsync)
    );

    assign xOrd       = r_x;
    assign yOrd       = r_y;
    assign visible    = r_visible;
    assign pixEn      = r_pix_en;
    assign lineStart  = r_line_start;
    assign frameStart = r_frame_start;
    assign frameCount = r_frame_cnt;

endmodule
